motor_ramp_ctrl: RTL and testbench

MOTOR_RAMP_CTRL -- requirements
Module: motor_ramp_ctrl

---
 rtl/motor_ramp_ctrl.sv | 173 +++++++++++++++++
 tb/tb_motor_ramp_ctrl.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/motor_ramp_ctrl.sv
// Motor speed ramp controller: accelerates/decelerates a PWM duty toward a
// target at a fixed tick rate, with controlled stop, emergency stop and a
// timed mechanical brake phase.
module motor_ramp_ctrl #(
    parameter int unsigned RAMP_DIV     = 1000,
    parameter int unsigned RAMP_STEP    = 1,
    parameter int unsigned BRAKE_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cmd_up,
    input  logic       cmd_down,
    input  logic       cmd_stop,
    input  logic       estop,
    input  logic [7:0] target_duty,
    output logic [7:0] duty_cycle,
    output logic       dir,
    output logic       brake,
    output logic       moving,
    output logic [2:0] state
);

    localparam int unsigned TICK_W  = 16;
    localparam int unsigned BRAKE_W = 20;
    localparam logic [TICK_W-1:0]  TICK_LAST  = TICK_W'(RAMP_DIV - 1);
    localparam logic [BRAKE_W-1:0] BRAKE_LAST = BRAKE_W'(BRAKE_CYCLES - 1);
    localparam logic [8:0]         STEP9      = 9'(RAMP_STEP);
    localparam logic [7:0]         STEP8      = 8'(RAMP_STEP);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ACCEL  = 3'd1,
        S_CRUISE = 3'd2,
        S_DECEL  = 3'd3,
        S_BRAKE  = 3'd4
    } state_t;

    state_t               state_q;
    logic                 stop_pending;
    logic [TICK_W-1:0]    tick_cnt;
    logic [BRAKE_W-1:0]   brake_cnt;

    logic                 tick;
    logic                 start_ok;
    logic [8:0]           up_sum;
    logic [7:0]           accel_duty;
    logic [7:0]           decel_floor;
    logic [7:0]           decel_duty;
    logic [TICK_W-1:0]    tick_adv;

    assign state = state_q;

    // Ramp arithmetic, done 9 bits wide so the duty never wraps either way
    always_comb begin
        tick        = (tick_cnt == TICK_LAST);
        start_ok    = (cmd_up ^ cmd_down) && (target_duty != 8'd0);
        up_sum      = {1'b0, duty_cycle} + STEP9;
        accel_duty  = (up_sum >= {1'b0, target_duty}) ? target_duty : up_sum[7:0];
        decel_floor = (stop_pending || cmd_stop) ? 8'd0 : target_duty;
        decel_duty  = ({1'b0, duty_cycle} <= (STEP9 + {1'b0, decel_floor}))
                      ? decel_floor : (duty_cycle - STEP8);
        tick_adv    = tick ? '0 : (tick_cnt + TICK_W'(1));
    end

    // State machine with registered outputs; estop > cmd_stop > target > start
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            duty_cycle   <= 8'd0;
            dir          <= 1'b0;
            brake        <= 1'b0;
            moving       <= 1'b0;
            stop_pending <= 1'b0;
            tick_cnt     <= '0;
            brake_cnt    <= '0;
        end else if (state_q == S_BRAKE) begin
            if (estop) begin
                brake_cnt <= '0;
            end else if (brake_cnt == BRAKE_LAST) begin
                state_q      <= S_IDLE;
                brake        <= 1'b0;
                moving       <= 1'b0;
                stop_pending <= 1'b0;
                brake_cnt    <= '0;
            end else begin
                brake_cnt <= brake_cnt + BRAKE_W'(1);
            end
        end else if (estop) begin
            state_q    <= S_BRAKE;
            duty_cycle <= 8'd0;
            brake      <= 1'b1;
            moving     <= 1'b1;
            brake_cnt  <= '0;
            tick_cnt   <= '0;
        end else if (state_q == S_IDLE) begin
            if (start_ok) begin
                state_q  <= S_ACCEL;
                dir      <= cmd_up;
                moving   <= 1'b1;
                tick_cnt <= '0;
            end
        end else if (cmd_stop) begin
            if (duty_cycle == 8'd0) begin
                state_q   <= S_BRAKE;
                brake     <= 1'b1;
                brake_cnt <= '0;
                tick_cnt  <= '0;
            end else begin
                stop_pending <= 1'b1;
                if (state_q != S_DECEL) begin
                    state_q  <= S_DECEL;
                    tick_cnt <= '0;
                end else begin
                    // Already ramping down: keep the tick phase, floor becomes 0
                    tick_cnt <= tick_adv;
                    if (tick) duty_cycle <= decel_duty;
                end
            end
        end else begin
            case (state_q)
                S_ACCEL: begin
                    if (duty_cycle == target_duty) begin
                        state_q  <= S_CRUISE;
                        tick_cnt <= '0;
                    end else if (target_duty < duty_cycle) begin
                        state_q      <= S_DECEL;
                        stop_pending <= 1'b0;
                        tick_cnt     <= '0;
                    end else begin
                        tick_cnt <= tick_adv;
                        if (tick) duty_cycle <= accel_duty;
                    end
                end
                S_CRUISE: begin
                    if (target_duty > duty_cycle) begin
                        state_q  <= S_ACCEL;
                        tick_cnt <= '0;
                    end else if (target_duty < duty_cycle) begin
                        state_q      <= S_DECEL;
                        stop_pending <= 1'b0;
                        tick_cnt     <= '0;
                    end
                end
                S_DECEL: begin
                    if (stop_pending) begin
                        if (duty_cycle == 8'd0) begin
                            state_q   <= S_BRAKE;
                            brake     <= 1'b1;
                            brake_cnt <= '0;
                            tick_cnt  <= '0;
                        end else begin
                            tick_cnt <= tick_adv;
                            if (tick) duty_cycle <= decel_duty;
                        end
                    end else if (duty_cycle == target_duty) begin
                        state_q  <= S_CRUISE;
                        tick_cnt <= '0;
                    end else if (target_duty > duty_cycle) begin
                        state_q  <= S_ACCEL;
                        tick_cnt <= '0;
                    end else begin
                        tick_cnt <= tick_adv;
                        if (tick) duty_cycle <= decel_duty;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_motor_ramp_ctrl.sv
// Bench for motor_ramp_ctrl: directed scenarios plus randomized traffic
// against a cycle-level behavioural model.
module tb_motor_ramp_ctrl;

    localparam int RAMP_DIV     = 4;
    localparam int RAMP_STEP    = 16;
    localparam int BRAKE_CYCLES = 8;

    localparam int ST_IDLE = 0, ST_ACCEL = 1, ST_CRUISE = 2, ST_DECEL = 3, ST_BRAKE = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       cmd_up = 1'b0, cmd_down = 1'b0, cmd_stop = 1'b0, estop = 1'b0;
    logic [7:0] target_duty = 8'd0;
    logic [7:0] duty_cycle;
    logic       dir, brake, moving;
    logic [2:0] state;

    int errors = 0;
    int checks = 0;

    motor_ramp_ctrl #(
        .RAMP_DIV(RAMP_DIV), .RAMP_STEP(RAMP_STEP), .BRAKE_CYCLES(BRAKE_CYCLES)
    ) dut (
        .clk(clk), .reset(reset), .cmd_up(cmd_up), .cmd_down(cmd_down),
        .cmd_stop(cmd_stop), .estop(estop), .target_duty(target_duty),
        .duty_cycle(duty_cycle), .dir(dir), .brake(brake), .moving(moving),
        .state(state)
    );

    always #5 clk = ~clk;

    // Behavioural reference: phase age drives ramp ticks, brake time counts down
    int   m_state = 0, m_duty = 0, m_age = 0, m_left = 0;
    logic m_dir = 1'b0, m_sp = 1'b0, m_brake = 1'b0, m_moving = 1'b0;

    always @(posedge clk) begin
        int  ns;
        int  tgt;
        bit  rtick;
        tgt   = int'(target_duty);
        rtick = ((m_age % RAMP_DIV) == RAMP_DIV - 1);
        ns    = m_state;
        if (reset) begin
            ns = ST_IDLE; m_duty = 0; m_dir = 1'b0; m_sp = 1'b0; m_left = 0;
        end else if (m_state == ST_BRAKE) begin
            if (estop) m_left = BRAKE_CYCLES - 1;
            else if (m_left == 0) begin ns = ST_IDLE; m_sp = 1'b0; end
            else m_left--;
        end else if (estop) begin
            ns = ST_BRAKE; m_duty = 0; m_left = BRAKE_CYCLES - 1;
        end else if (m_state == ST_IDLE) begin
            if ((cmd_up != cmd_down) && tgt != 0) begin ns = ST_ACCEL; m_dir = cmd_up; end
        end else if (cmd_stop) begin
            if (m_duty == 0) begin ns = ST_BRAKE; m_left = BRAKE_CYCLES - 1; end
            else begin
                m_sp = 1'b1;
                if (m_state != ST_DECEL) ns = ST_DECEL;
                else if (rtick) m_duty = (m_duty - RAMP_STEP < 0) ? 0 : m_duty - RAMP_STEP;
            end
        end else begin
            case (m_state)
                ST_ACCEL:
                    if (m_duty == tgt) ns = ST_CRUISE;
                    else if (tgt < m_duty) begin ns = ST_DECEL; m_sp = 1'b0; end
                    else if (rtick) m_duty = (m_duty + RAMP_STEP > tgt) ? tgt : m_duty + RAMP_STEP;
                ST_CRUISE:
                    if (tgt > m_duty) ns = ST_ACCEL;
                    else if (tgt < m_duty) begin ns = ST_DECEL; m_sp = 1'b0; end
                ST_DECEL:
                    if (m_sp) begin
                        if (m_duty == 0) begin ns = ST_BRAKE; m_left = BRAKE_CYCLES - 1; end
                        else if (rtick) m_duty = (m_duty - RAMP_STEP < 0) ? 0 : m_duty - RAMP_STEP;
                    end else if (m_duty == tgt) ns = ST_CRUISE;
                    else if (tgt > m_duty) ns = ST_ACCEL;
                    else if (rtick) m_duty = (m_duty - RAMP_STEP < tgt) ? tgt : m_duty - RAMP_STEP;
                default: ns = ST_IDLE;
            endcase
        end
        m_age    = (ns != m_state || reset) ? 0 : m_age + 1;
        m_state  = ns;
        m_brake  = (ns == ST_BRAKE);
        m_moving = (ns != ST_IDLE);
    end

    task automatic clocks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic go_idle();
        cmd_up = 0; cmd_down = 0; cmd_stop = 0; estop = 0;
        reset = 1; clocks(1); reset = 0;
    endtask

    task automatic test_reset();
        reset = 1; estop = 1; cmd_up = 1; cmd_stop = 1; target_duty = 8'd64;
        clocks(2);
        checks++; if (state !== 3'd0) begin errors++; $display("FAIL reset_state got=%0d exp=0", state); end
        checks++; if (duty_cycle !== 8'd0) begin errors++; $display("FAIL reset_duty got=%0d exp=0", duty_cycle); end
        checks++; if ({dir, brake, moving} !== 3'b000) begin errors++; $display("FAIL reset_flags got=%b exp=000", {dir, brake, moving}); end
        reset = 0; estop = 0; cmd_up = 0; cmd_stop = 0;
        clocks(1);
        checks++; if (state !== 3'd0) begin errors++; $display("FAIL reset_release_state got=%0d exp=0", state); end
    endtask

    task automatic test_start_ramp();
        go_idle();
        target_duty = 8'd64; cmd_up = 1; clocks(1); cmd_up = 0;
        checks++; if (state !== 3'd1 || dir !== 1'b1 || moving !== 1'b1) begin
            errors++; $display("FAIL start_accel got state=%0d dir=%b moving=%b exp 1/1/1", state, dir, moving); end
        for (int k = 1; k <= 4; k++) begin
            clocks(4);
            checks++; if (duty_cycle !== 8'(16 * k)) begin
                errors++; $display("FAIL start_step%0d got=%0d exp=%0d", k, duty_cycle, 16 * k); end
        end
        clocks(1);
        checks++; if (state !== 3'd2 || duty_cycle !== 8'd64) begin
            errors++; $display("FAIL start_cruise got state=%0d duty=%0d exp 2/64", state, duty_cycle); end
    endtask

    task automatic test_controlled_stop();
        int n;
        cmd_stop = 1; clocks(1); cmd_stop = 0;
        checks++; if (state !== 3'd3) begin errors++; $display("FAIL stop_decel got=%0d exp=3", state); end
        for (int k = 1; k <= 4; k++) begin
            clocks(4);
            checks++; if (duty_cycle !== 8'(64 - 16 * k)) begin
                errors++; $display("FAIL stop_step%0d got=%0d exp=%0d", k, duty_cycle, 64 - 16 * k); end
        end
        clocks(1);
        checks++; if (state !== 3'd4 || brake !== 1'b1 || duty_cycle !== 8'd0) begin
            errors++; $display("FAIL stop_brake got state=%0d brake=%b duty=%0d exp 4/1/0", state, brake, duty_cycle); end
        n = 1;
        while (brake === 1'b1 && n < 30) begin clocks(1); if (brake === 1'b1) n++; end
        checks++; if (n !== BRAKE_CYCLES) begin errors++; $display("FAIL stop_brake_len got=%0d exp=%0d", n, BRAKE_CYCLES); end
        checks++; if (state !== 3'd0 || moving !== 1'b0) begin
            errors++; $display("FAIL stop_idle got state=%0d moving=%b exp 0/0", state, moving); end
    endtask

    task automatic test_clamp();
        go_idle();
        target_duty = 8'd40; cmd_down = 1; clocks(1); cmd_down = 0;
        checks++; if (dir !== 1'b0 || state !== 3'd1) begin
            errors++; $display("FAIL clamp_start got dir=%b state=%0d exp 0/1", dir, state); end
        clocks(4);
        checks++; if (duty_cycle !== 8'd16) begin errors++; $display("FAIL clamp_s1 got=%0d exp=16", duty_cycle); end
        clocks(4);
        checks++; if (duty_cycle !== 8'd32) begin errors++; $display("FAIL clamp_s2 got=%0d exp=32", duty_cycle); end
        clocks(4);
        checks++; if (duty_cycle !== 8'd40) begin errors++; $display("FAIL clamp_s3 got=%0d exp=40", duty_cycle); end
        clocks(1);
        checks++; if (state !== 3'd2 || duty_cycle !== 8'd40) begin
            errors++; $display("FAIL clamp_cruise got state=%0d duty=%0d exp 2/40", state, duty_cycle); end
    endtask

    task automatic test_saturation();
        go_idle();
        target_duty = 8'd250; cmd_up = 1; clocks(1); cmd_up = 0;
        clocks(4 * 15);
        checks++; if (duty_cycle !== 8'd240) begin errors++; $display("FAIL sat_240 got=%0d exp=240", duty_cycle); end
        clocks(4);
        checks++; if (duty_cycle !== 8'd250) begin errors++; $display("FAIL sat_250 got=%0d exp=250", duty_cycle); end
        clocks(9);
        checks++; if (state !== 3'd2 || duty_cycle !== 8'd250) begin
            errors++; $display("FAIL sat_hold got state=%0d duty=%0d exp 2/250", state, duty_cycle); end
    endtask

    task automatic test_estop();
        int n;
        go_idle();
        target_duty = 8'd64; cmd_up = 1; clocks(1); cmd_up = 0;
        clocks(8);
        checks++; if (duty_cycle !== 8'd32 || state !== 3'd1) begin
            errors++; $display("FAIL estop_pre got duty=%0d state=%0d exp 32/1", duty_cycle, state); end
        estop = 1; clocks(1);
        checks++; if (duty_cycle !== 8'd0 || state !== 3'd4 || brake !== 1'b1) begin
            errors++; $display("FAIL estop_brake got duty=%0d state=%0d brake=%b exp 0/4/1", duty_cycle, state, brake); end
        clocks(5); estop = 0;
        n = 0;
        while (state !== 3'd0 && n < 30) begin clocks(1); n++; end
        checks++; if (n !== BRAKE_CYCLES) begin errors++; $display("FAIL estop_release got=%0d exp=%0d", n, BRAKE_CYCLES); end
    endtask

    task automatic test_ignored();
        go_idle();
        target_duty = 8'd0; cmd_up = 1; clocks(2); cmd_up = 0;
        checks++; if (state !== 3'd0) begin errors++; $display("FAIL ign_zero_target got=%0d exp=0", state); end
        target_duty = 8'd64; cmd_up = 1; cmd_down = 1; clocks(3); cmd_up = 0; cmd_down = 0;
        checks++; if (state !== 3'd0 || moving !== 1'b0) begin
            errors++; $display("FAIL ign_both got state=%0d moving=%b exp 0/0", state, moving); end
        cmd_up = 1; clocks(1); cmd_up = 0;
        cmd_down = 1; clocks(6); cmd_down = 0;
        checks++; if (dir !== 1'b1 || state !== 3'd1 || duty_cycle !== 8'd16) begin
            errors++; $display("FAIL ign_down_accel got dir=%b state=%0d duty=%0d exp 1/1/16", dir, state, duty_cycle); end
        cmd_stop = 1; clocks(1); cmd_stop = 0;
        checks++; if (state !== 3'd3) begin errors++; $display("FAIL ign_decel got=%0d exp=3", state); end
        reset = 1; clocks(1); reset = 0;
        checks++; if (state !== 3'd0 || duty_cycle !== 8'd0 || {dir, brake, moving} !== 3'b000) begin
            errors++; $display("FAIL ign_reset_decel got state=%0d duty=%0d flags=%b exp 0/0/000", state, duty_cycle, {dir, brake, moving}); end
    endtask

    task automatic test_random();
        go_idle();
        target_duty = 8'($urandom_range(1, 255));
        for (int i = 0; i < 4000; i++) begin
            checks++; if (int'(state) !== m_state) begin errors++; $display("FAIL rnd_state cyc=%0d got=%0d exp=%0d", i, state, m_state); end
            checks++; if (int'(duty_cycle) !== m_duty) begin errors++; $display("FAIL rnd_duty cyc=%0d got=%0d exp=%0d", i, duty_cycle, m_duty); end
            checks++; if ({dir, brake, moving} !== {m_dir, m_brake, m_moving}) begin
                errors++; $display("FAIL rnd_flags cyc=%0d got=%b exp=%b", i, {dir, brake, moving}, {m_dir, m_brake, m_moving}); end
            cmd_up   = ($urandom_range(0, 7) == 0);
            cmd_down = ($urandom_range(0, 7) == 0);
            cmd_stop = ($urandom_range(0, 59) == 0);
            estop    = ($urandom_range(0, 149) == 0);
            reset    = ($urandom_range(0, 799) == 0);
            if ($urandom_range(0, 39) == 0)
                target_duty = ($urandom_range(0, 9) == 0) ? 8'd0 : 8'($urandom_range(0, 255));
            clocks(1);
        end
        cmd_up = 0; cmd_down = 0; cmd_stop = 0; estop = 0; reset = 0;
    endtask

    initial begin
        clocks(1);
        test_reset();
        test_start_ramp();
        test_controlled_stop();
        test_clamp();
        test_saturation();
        test_estop();
        test_ignored();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
